// File: rtl/knn_memory_responder.sv
// knn_memory_responder: on-chip word memory serving the KNN controller bus.
//   clk, rst (async, active-low)
//   read/readaddress          -> readdata/readdatavalid after READ_LATENCY edges
//   write/writeaddress/writedata
//   clear      : start a zero-fill sweep (taken in SERVE only)
//   busy       : high while sweeping; requests are dropped then
//   addr_error : sticky illegal-address flag, cleared by err_clear
module knn_memory_responder #(
  parameter int unsigned W            = 32,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned ADDR_STEP    = 32,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic [ADDR_W-1:0] readaddress,
  output logic [W-1:0]      readdata,
  output logic              readdatavalid,
  input  logic              write,
  input  logic [ADDR_W-1:0] writeaddress,
  input  logic [W-1:0]      writedata,
  input  logic              clear,
  output logic              busy,
  output logic              addr_error,
  input  logic              err_clear
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP_A  = ADDR_W'(ADDR_STEP);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_SERVE
  } state_e;

  // Legal iff at/above base, aligned to the stride, and inside the array
  function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_A;
    return (a >= BASE_A) && ((off % STEP_A) == '0) && ((off / STEP_A) < DEPTH_A);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_A) / STEP_A);
  endfunction

  logic [W-1:0] mem_q [DEPTH];

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        sweep_q, sweep_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;
  logic [READ_LATENCY-1:0] pv_q;
  logic [W-1:0]            pd_q [READ_LATENCY];
  logic [W-1:0]            rdata_q;
  logic                    rvalid_q;

  logic             rd_legal, wr_legal, serve;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [W-1:0]     rd_word;
  logic             rd_accept;
  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr;
  logic [W-1:0]     mem_wdata;

  // Address decode for both request ports
  always_comb begin
    rd_legal = addr_legal(readaddress);
    wr_legal = addr_legal(writeaddress);
    rd_idx   = addr_idx(readaddress);
    wr_idx   = addr_idx(writeaddress);
    serve    = (state_q == ST_SERVE);
    // Array is sampled before this edge's write lands: read-before-write
    rd_word  = rd_legal ? mem_q[rd_idx] : '0;
  end

  // Next-state, sweep, single write port and error flag
  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    busy_d    = busy_q;
    err_d     = err_q;
    rd_accept = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = sweep_q;
    mem_wdata = '0;
    case (state_q)
      ST_CLEAR: begin
        mem_we = 1'b1;
        if (sweep_q == LAST_IDX) begin
          sweep_d = '0;
          busy_d  = 1'b0;
          state_d = ST_SERVE;
        end else begin
          sweep_d = sweep_q + IDX_W'(1);
        end
      end
      ST_SERVE: begin
        rd_accept = read;
        if (write && wr_legal) begin
          mem_we    = 1'b1;
          mem_waddr = wr_idx;
          mem_wdata = writedata;
        end
        // Requests at the clear edge are still serviced above
        if (clear) begin
          state_d = ST_CLEAR;
          busy_d  = 1'b1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
    if (err_clear) err_d = 1'b0;
    // A new illegal request wins over err_clear
    if (serve && ((read && !rd_legal) || (write && !wr_legal))) err_d = 1'b1;
  end

  // Control, read pipeline and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_CLEAR;
      sweep_q  <= '0;
      busy_q   <= 1'b1;
      err_q    <= 1'b0;
      pv_q     <= '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) pd_q[i] <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      pv_q[0] <= rd_accept;
      pd_q[0] <= rd_word;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        pv_q[i] <= pv_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
      rvalid_q <= pv_q[READ_LATENCY-1];
      // readdata holds between returns
      if (pv_q[READ_LATENCY-1]) rdata_q <= pd_q[READ_LATENCY-1];
    end
  end

  // Storage array: no reset, zeroed by the sweep
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign readdata      = rdata_q;
  assign readdatavalid = rvalid_q;
  assign busy          = busy_q;
  assign addr_error    = err_q;

endmodule

// File: doc/knn_memory_responder.md
Name: knn_memory_responder

Overview:
- Single-port-per-direction memory target that answers the KNN memory controller's simple bus: read/readaddress/readdata and write/writeaddress/writedata.
- Holds training records, input records and inferred-type slots in an on-chip word array.
- Provides a fixed, pipelined read latency and a post-reset zero-fill sweep.
- Flags illegal addresses through a sticky error bit.

Parameters:
- W, 32, data word width in bits
- ADDR_W, 32, address width
- DEPTH, 256, number of W-bit words stored
- BASE_ADDR, 0, address of word 0
- ADDR_STEP, 32, address increment between consecutive words (matches controller stride of W)
- READ_LATENCY, 2, cycles from read sample edge to readdata update; legal range 1..8

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- read  in  1  read request, sampled every rising edge; one request per high cycle
- readaddress  in  ADDR_W  read address, sampled with read
- readdata  out  W  read return data, held until next return
- readdatavalid  out  1  one-cycle pulse when readdata updates
- write  in  1  write request, sampled every rising edge
- writeaddress  in  ADDR_W  write address
- writedata  in  W  write data
- clear  in  1  request a zero-fill sweep (honoured in SERVE only)
- busy  out  1  high while sweeping; requests ignored
- addr_error  out  1  sticky illegal-address flag
- err_clear  in  1  clears addr_error

Behaviour:
- Reset (rst low, asynchronous):
  - readdata=0, readdatavalid=0, addr_error=0, busy=1.
  - Read pipeline emptied, sweep counter=0, FSM=CLEAR.
  - Array contents are not reset directly; the sweep zeroes them.
- FSM CLEAR:
  - Each cycle writes 0 to word[sweep counter] and increments the counter.
  - After writing word DEPTH-1: counter=0, busy<=0, FSM=SERVE. Sweep takes exactly DEPTH cycles after reset release.
  - read/write sampled during CLEAR are dropped: no valid pulse, no error.
- FSM SERVE:
  - Services requests.
  - clear=1 at an edge: FSM<=CLEAR, busy<=1 from that edge. The read/write sampled at that same edge is still serviced.
  - Reads already in the pipeline complete normally with the data captured at their sample edge.
- Address decode, per request: offset=addr-BASE_ADDR. The address is legal iff all of:
  - addr>=BASE_ADDR
  - offset mod ADDR_STEP==0
  - offset/ADDR_STEP<DEPTH
- Read: read=1 sampled at edge T in SERVE.
  - Array word is read at T into stage 1 of a READ_LATENCY-deep valid/data shift pipeline.
  - At edge T+READ_LATENCY: readdata<=word, readdatavalid<=1 for exactly one cycle.
  - Fully pipelined: reads on consecutive cycles return on consecutive cycles in order.
  - Illegal read address: returns 0 with normal valid timing and sets addr_error.
- Write: write=1 sampled at edge T in SERVE with a legal address stores writedata at T.
  - Illegal write address: write dropped, addr_error set.
- Read and write in the same cycle to the same word: read returns old data (read-before-write).
- Write at T, read of the same word at T+1: returns new data.
- addr_error:
  - Set on any illegal request in SERVE.
  - err_clear=1 clears it, except that a new illegal request in the same cycle keeps it 1 (set wins).
- readdata holds its last value between pulses, including across CLEAR.
- rst asserted mid-read: pending returns are discarded, with no valid pulse after reset.
- The controller samples readdata 3 edges after its read sample edge, so READ_LATENCY must be ≤3 in the KNN system. The default of 2 meets this.

Test Plan:
- Reset release -> busy high exactly 256 cycles then low. Afterwards, read of 0x0 and of 0x1FE0 each return 0 with readdatavalid 2 cycles after request.
- Write 0xDEADBEEF to 0x20, then read 0x20 next cycle -> readdata=0xDEADBEEF, valid pulse at request edge+2, addr_error=0.
- Same-cycle write 0x5 and read of 0x40 (old 0x3) -> read returns 0x3. A following read returns 0x5.
- Back-to-back reads of 0x0, 0x20, 0x40 holding 1, 2, 3 -> valid high three consecutive cycles with 1, 2, 3 in order.
- Read 0x2000 (offset 256*32) and write 0x21 (misaligned) -> read returns 0, write does not modify memory, addr_error=1. err_clear with a simultaneous illegal read -> stays 1. err_clear alone -> 0.
- Read issued 1 cycle before clear=1 -> old data still returned. Busy for 256 cycles, requests dropped. Afterwards the location reads 0.
